// File: rtl/gaussian_window_filter.sv
// gaussian_window_filter: 3x3 Gaussian ([1 2 1; 2 4 2; 1 2 1] / 16) over a column stream.
// Accepts top/mid/bot columns from the line buffer, tracks raster position and emits only
// interior pixels with end-of-line / end-of-frame markers.
// Optional build macro GAUSS_ROUND_EN: round half up instead of truncating the final divide.
module gaussian_window_filter #(
    parameter int unsigned W = 64,
    parameter int unsigned H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] top,
    input  logic [7:0] mid,
    input  logic [7:0] bot,
    input  logic       valid_in,
    output logic [7:0] pixel_out,
    output logic       valid_out,
    output logic       eol_out,
    output logic       eof_out
);

    localparam int unsigned CW = (W > 2) ? $clog2(W) : 2;
    localparam int unsigned RW = (H > 2) ? $clog2(H) : 2;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          last_col;
    logic          last_row;
    logic          win_done;

    // Window columns packed as {top, mid, bot}
    logic [23:0] win_l_q, win_c_q, win_r_q;
    logic        v0_q, eol0_q, eof0_q;

    logic [9:0]  cs_l_q, cs_c_q, cs_r_q;
    logic        v1_q, eol1_q, eof1_q;

    logic [11:0] sum_total;
    logic [11:0] sum_adj;

    function automatic logic [9:0] col_sum(input logic [23:0] c);
        return {2'b00, c[23:16]} + {1'b0, c[15:8], 1'b0} + {2'b00, c[7:0]};
    endfunction

    // Position decode for the column currently being presented
    always_comb begin
        last_col = (col_q == CW'(W - 1));
        last_row = (row_q == RW'(H - 1));
        win_done = (row_q >= RW'(2)) && (col_q >= CW'(2));
    end

    // Raster position counters, advanced once per accepted column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (valid_in) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Window shift on accepted columns; flags tag the window completed by this column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_l_q <= '0;
            win_c_q <= '0;
            win_r_q <= '0;
            v0_q    <= 1'b0;
            eol0_q  <= 1'b0;
            eof0_q  <= 1'b0;
        end else begin
            if (valid_in) begin
                win_l_q <= win_c_q;
                win_c_q <= win_r_q;
                win_r_q <= {top, mid, bot};
            end
            v0_q   <= valid_in && win_done;
            eol0_q <= valid_in && win_done && last_col;
            eof0_q <= valid_in && win_done && last_col && last_row;
        end
    end

    // Stage 1: vertical 1-2-1 sums of the three window columns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_l_q <= '0;
            cs_c_q <= '0;
            cs_r_q <= '0;
            v1_q   <= 1'b0;
            eol1_q <= 1'b0;
            eof1_q <= 1'b0;
        end else begin
            cs_l_q <= col_sum(win_l_q);
            cs_c_q <= col_sum(win_c_q);
            cs_r_q <= col_sum(win_r_q);
            v1_q   <= v0_q;
            eol1_q <= eol0_q;
            eof1_q <= eof0_q;
        end
    end

    // Horizontal 1-2-1 combine; max 4080 (+8 when rounding) still fits 12 bits
    always_comb begin
        sum_total = {2'b00, cs_l_q} + {1'b0, cs_c_q, 1'b0} + {2'b00, cs_r_q};
`ifdef GAUSS_ROUND_EN
        sum_adj   = sum_total + 12'd8;
`else
        sum_adj   = sum_total;
`endif
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out <= '0;
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else begin
            pixel_out <= sum_adj[11:4];
            valid_out <= v1_q;
            eol_out   <= eol1_q;
            eof_out   <= eof1_q;
        end
    end

endmodule

// File: tb/tb_gaussian_window_filter.sv
// Directed bench for gaussian_window_filter on a small 5x4 frame.
module tb_gaussian_window_filter;

    localparam int unsigned W    = 5;
    localparam int unsigned H    = 4;
    localparam int          NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] top = '0, mid = '0, bot = '0;
    logic       valid_in = 1'b0;
    logic [7:0] pixel_out;
    logic       valid_out, eol_out, eof_out;

    gaussian_window_filter #(.W(W), .H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .top      (top),
        .mid      (mid),
        .bot      (bot),
        .valid_in (valid_in),
        .pixel_out(pixel_out),
        .valid_out(valid_out),
        .eol_out  (eol_out),
        .eof_out  (eof_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int img[H][W];
    int exp_q[$];
    int got_pix[$], got_eol[$], got_eof[$];
    int first_cyc  = -1;
    int accept_cyc = -1;
    int n_checks   = 0;
    int n_pass     = 0;

    // Capture every output beat away from the active edge
    always @(negedge clk) begin
        if (valid_out) begin
            got_pix.push_back(int'(pixel_out));
            got_eol.push_back(int'(eol_out));
            got_eof.push_back(int'(eof_out));
            if (first_cyc < 0) first_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input int got, input int expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    // Plain 2D convolution of the stored image, centre (r, c)
    function automatic int ref_pix(input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += img[r + dr][c + dc] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
`ifdef GAUSS_ROUND_EN
        return (s + 8) / 16;
`else
        return s / 16;
`endif
    endfunction

    task automatic clear_got();
        got_pix.delete();
        got_eol.delete();
        got_eof.delete();
        exp_q.delete();
        first_cyc  = -1;
        accept_cyc = -1;
    endtask

    // Present ncols columns in raster order, as the line buffer would; optional idle gaps
    task automatic send_frame(input bit gaps, input int ncols);
        int n = 0;
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                if (n < ncols) begin
                    if (gaps) begin
                        for (int k = 0; k < 3; k++) begin
                            if ($urandom_range(0, 1) == 1) begin
                                valid_in = 1'b0;
                                @(posedge clk); #1;
                            end
                        end
                    end
                    top = (r >= 2) ? 8'(img[r-2][c]) : 8'd0;
                    mid = (r >= 1) ? 8'(img[r-1][c]) : 8'd0;
                    bot = 8'(img[r][c]);
                    valid_in = 1'b1;
                    if (r == 2 && c == 2) accept_cyc = cyc + 1;
                    @(posedge clk); #1;
                    n++;
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_out(input string tag);
        check_eq({tag, "_count"}, got_pix.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_pix.size()) begin
                check_eq($sformatf("%s_pix%0d", tag, i), got_pix[i], exp_q[i]);
                check_eq($sformatf("%s_eol%0d", tag, i), got_eol[i],
                         int'((i % (W - 2)) == (W - 3)));
                check_eq($sformatf("%s_eof%0d", tag, i), got_eof[i],
                         int'((i % NOUT) == (NOUT - 1)));
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++) img[r][c] = v;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++) img[r][c] = 40 * c;
    endtask

    task automatic push_ramp_exp();
        for (int r = 1; r < int'(H) - 1; r++)
            for (int c = 1; c < int'(W) - 1; c++) exp_q.push_back(40 * c);
    endtask

    initial begin
        int imp_exp[6];
`ifdef GAUSS_ROUND_EN
        imp_exp = '{32, 64, 32, 16, 32, 16};
`else
        imp_exp = '{31, 63, 31, 15, 31, 15};
`endif

        // Reset state
        #12;
        check_eq("rst_pixel", int'(pixel_out), 0);
        check_eq("rst_valid", int'(valid_out), 0);
        check_eq("rst_eol", int'(eol_out), 0);
        check_eq("rst_eof", int'(eof_out), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant 100 with latency check
        clear_got();
        fill_const(100);
        repeat (NOUT) exp_q.push_back(100);
        send_frame(1'b0, W * H);
        drain();
        compare_out("const");
        check_eq("latency", first_cyc - accept_cyc, 2);

        // Impulse 255 at row 1, col 2
        clear_got();
        fill_const(0);
        img[1][2] = 255;
        foreach (imp_exp[i]) exp_q.push_back(imp_exp[i]);
        send_frame(1'b0, W * H);
        drain();
        compare_out("impulse");

        // Horizontal ramp is reproduced exactly
        clear_got();
        fill_ramp();
        push_ramp_exp();
        send_frame(1'b0, W * H);
        drain();
        compare_out("ramp");

        // Random image with random valid_in gaps
        clear_got();
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++) img[r][c] = int'($urandom_range(0, 255));
        for (int r = 1; r < int'(H) - 1; r++)
            for (int c = 1; c < int'(W) - 1; c++) exp_q.push_back(ref_pix(r, c));
        send_frame(1'b1, W * H);
        drain();
        compare_out("gaps");

        // Back-to-back frames: constant then ramp, no idle between them
        clear_got();
        repeat (NOUT) exp_q.push_back(100);
        push_ramp_exp();
        fill_const(100);
        send_frame(1'b0, W * H);
        fill_ramp();
        send_frame(1'b0, W * H);
        drain();
        compare_out("b2b");

        // Reset with a pixel on the outputs and more in flight
        clear_got();
        fill_const(100);
        send_frame(1'b0, 2 * W + W);
        check_eq("inflight_valid", int'(valid_out), 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pixel", int'(pixel_out), 0);
        check_eq("midrst_valid", int'(valid_out), 0);
        check_eq("midrst_eol", int'(eol_out), 0);
        check_eq("midrst_eof", int'(eof_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_got();
        fill_ramp();
        push_ramp_exp();
        send_frame(1'b0, W * H);
        drain();
        compare_out("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
